// File: rtl/regblock_pkg.sv
// Shared widths, FSM state encoding, ALU op codes and instruction field positions
// for the RegBlock sequencer.
package regblock_pkg;

    localparam int RWIDTH = 6;
    localparam int DWIDTH = 32;
    localparam int IMM_IN = 15;
    localparam int IWIDTH = 32;
    localparam int OPW    = 4;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 28;
    localparam int IMMF_BIT = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 21;
    localparam int RS_HI    = 20;
    localparam int RS_LO    = 15;
    localparam int RT_HI    = 14;
    localparam int RT_LO    = 9;
    localparam int IMM_HI   = 14;
    localparam int IMM_LO   = 0;

    localparam logic [OPW-1:0] OP_ADD = 4'h0;
    localparam logic [OPW-1:0] OP_SUB = 4'h1;
    localparam logic [OPW-1:0] OP_AND = 4'h2;
    localparam logic [OPW-1:0] OP_OR  = 4'h3;
    localparam logic [OPW-1:0] OP_XOR = 4'h4;
    localparam logic [OPW-1:0] OP_SLL = 4'h5;
    localparam logic [OPW-1:0] OP_SRL = 4'h6;
    localparam logic [OPW-1:0] NOP_OP = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic [OPW-1:0]    op;
        logic              imm_flag;
        logic [RWIDTH-1:0] rd;
        logic [RWIDTH-1:0] rs;
        logic [RWIDTH-1:0] rt;
        logic [IMM_IN-1:0] imm;
    } fields_t;

endpackage

// File: rtl/regblock_decode.sv
// Instruction field extraction from the latched instruction register.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module regblock_decode
    import regblock_pkg::*;
(
    input  logic [IWIDTH-1:0] instr_q,
    output fields_t           fld
);

    always_comb begin
        fld          = '0;
        fld.op       = instr_q[OP_HI:OP_LO];
        fld.imm_flag = instr_q[IMMF_BIT];
        fld.rd       = instr_q[RD_HI:RD_LO];
        fld.rs       = instr_q[RS_HI:RS_LO];
        fld.imm      = instr_q[IMM_HI:IMM_LO];
        // Immediate forms carry no second register operand.
        fld.rt       = instr_q[IMMF_BIT] ? '0 : instr_q[RT_HI:RT_LO];
    end

endmodule

// File: rtl/regblock_seq.sv
// Sequencer driving RegBlock read/ALU/write-back from one instruction word.
// Latency: accept to done = 4 cycles (3 for NOP_OP); one instruction per 5 cycles.
// Backpressure: instr_ready high only in IDLE; instr_valid is ignored elsewhere.
module regblock_seq
    import regblock_pkg::*;
#(
    parameter int CWIDTH = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IWIDTH-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [RWIDTH-1:0] rs,
    output logic [RWIDTH-1:0] rt,
    output logic [RWIDTH-1:0] rd,
    output logic [DWIDTH-1:0] wd,
    output logic              we,
    output logic              muxsel1,
    output logic [IMM_IN-1:0] imm_in,
    output logic [OPW-1:0]    ALUopsel,
    input  logic [DWIDTH-1:0] ALUresult,
    output logic              done,
    output logic [DWIDTH-1:0] result,
    output logic [CWIDTH-1:0] retired
);

    state_t            state;
    state_t            state_nxt;
    logic [IWIDTH-1:0] instr_q;
    logic [DWIDTH-1:0] result_q;
    logic [CWIDTH-1:0] retired_q;
    logic              accept;
    fields_t           fld;

    regblock_decode u_decode (
        .instr_q (instr_q),
        .fld     (fld)
    );

    assign accept = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? DECODE : IDLE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = (fld.op == NOP_OP) ? DONE : WB;
            WB:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write enable is decoded from state so an asynchronous reset drops it at once.
    always_comb begin
        instr_ready = 1'b0;
        we          = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:    instr_ready = 1'b1;
            WB:      we          = (fld.rd != '0);
            DONE:    done        = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            result_q  <= '0;
            retired_q <= '0;
        end else begin
            if (accept) begin
                instr_q <= instr;
            end
            if (state == EXEC) begin
                result_q <= ALUresult;
            end
            if (state == DONE) begin
                retired_q <= retired_q + CWIDTH'(1);
            end
        end
    end

    // Field drives come straight from the instruction register, so they hold
    // through the whole instruction and keep their last values in IDLE.
    assign rs       = fld.rs;
    assign rt       = fld.rt;
    assign rd       = fld.rd;
    assign muxsel1  = fld.imm_flag;
    assign imm_in   = fld.imm;
    assign ALUopsel = fld.op;
    assign wd       = result_q;
    assign result   = result_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_regblock_seq.sv
// Directed plus randomized bench for regblock_seq with a per-instruction reference model;
// a second instance with a 2-bit retire counter checks wrap-around.
module tb_regblock_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] alu_res;

    logic        instr_ready, we, muxsel1, done;
    logic [5:0]  rs, rt, rd;
    logic [31:0] wd, result;
    logic [14:0] imm_in;
    logic [3:0]  ALUopsel;
    logic [15:0] retired;

    logic        w_instr_ready, w_we, w_muxsel1, w_done;
    logic [5:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_wd, w_result;
    logic [14:0] w_imm_in;
    logic [3:0]  w_ALUopsel;
    logic [1:0]  w_retired;

    int n_cmp = 0;
    int n_err = 0;
    int model_retired = 0;

    always #5 clk = ~clk;

    regblock_seq #(.CWIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rs(rs), .rt(rt), .rd(rd), .wd(wd), .we(we),
        .muxsel1(muxsel1), .imm_in(imm_in), .ALUopsel(ALUopsel), .ALUresult(alu_res),
        .done(done), .result(result), .retired(retired)
    );

    regblock_seq #(.CWIDTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(w_instr_ready), .rs(w_rs), .rt(w_rt), .rd(w_rd), .wd(w_wd), .we(w_we),
        .muxsel1(w_muxsel1), .imm_in(w_imm_in), .ALUopsel(w_ALUopsel), .ALUresult(alu_res),
        .done(w_done), .result(w_result), .retired(w_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic f,
                                       input logic [5:0] d, input logic [5:0] s,
                                       input logic [14:0] lo);
        return {op, f, d, s, lo};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after DONE (back in IDLE).
    // With hold set, instr_valid stays high carrying nxt while the sequencer is busy.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] alu,
                             input bit hold, input logic [31:0] nxt);
        logic [3:0]  e_op;
        logic [5:0]  e_rd, e_rs, e_rt;
        logic [14:0] e_imm;
        bit          nop;
        int          lat;
        e_op  = ins[31:28];
        e_rd  = ins[26:21];
        e_rs  = ins[20:15];
        e_rt  = ins[27] ? 6'd0 : ins[14:9];
        e_imm = ins[14:0];
        nop   = (e_op == 4'hF);
        lat   = nop ? 3 : 4;
        chk("ready_idle", 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        alu_res     = alu;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            instr_valid = hold;
            instr       = hold ? nxt : $urandom;
            if (k >= 3) alu_res = $urandom;
            chk("ready_busy", 32'(instr_ready), 32'd0);
            chk("rs", 32'(rs), 32'(e_rs));
            chk("rt", 32'(rt), 32'(e_rt));
            chk("rd", 32'(rd), 32'(e_rd));
            chk("muxsel1", 32'(muxsel1), 32'(ins[27]));
            chk("imm_in", 32'(imm_in), 32'(e_imm));
            chk("aluop", 32'(ALUopsel), 32'(e_op));
            chk("we", 32'(we), 32'(!nop && k == 3 && e_rd != 6'd0));
            chk("done", 32'(done), 32'(k == lat));
            if (k == lat) chk("wd_done", wd, alu);
        end
        @(negedge clk);
        model_retired++;
        chk("retired", 32'(retired), 32'(model_retired % 65536));
        chk("retired_wrap", 32'(w_retired), 32'(model_retired % 4));
        chk("ready_after", 32'(instr_ready), 32'd1);
        chk("done_after", 32'(done), 32'd0);
        chk("we_after", 32'(we), 32'd0);
        chk("rd_hold_idle", 32'(rd), 32'(e_rd));
        chk("result", result, alu);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        alu_res     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_retired = 0;
    endtask

    initial begin
        logic [31:0] ins, ins2;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        alu_res     = '0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rs", 32'(rs), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        do_reset();

        // register op, immediate op, NOP, rd = 0
        run_instr(mk(4'h2, 1'b0, 6'h0C, 6'h03, {6'h29, 9'h000}), 32'hFFAAFFAA, 1'b0, 32'h0);
        run_instr(mk(4'h0, 1'b1, 6'h3F, 6'h23, 15'h1FFF), 32'h12345678, 1'b0, 32'h0);
        run_instr(mk(4'hF, 1'b0, 6'h05, 6'h01, 15'h0A00), 32'hDEADBEEF, 1'b0, 32'h0);
        run_instr(mk(4'h1, 1'b0, 6'h00, 6'h02, 15'h0600), 32'hCAFEF00D, 1'b0, 32'h0);

        // back-to-back with instr_valid held high
        ins  = mk(4'h3, 1'b0, 6'h11, 6'h07, {6'h09, 9'h000});
        ins2 = mk(4'h4, 1'b1, 6'h22, 6'h08, 15'h5555);
        run_instr(ins, 32'h0BADF00D, 1'b1, ins2);
        run_instr(ins2, 32'h600DCAFE, 1'b0, 32'h0);

        for (int i = 0; i < 20; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[26:21] = 6'd0;
            if ($urandom_range(0, 4) == 0) ins[31:28] = 4'hF;
            run_instr(ins, $urandom, 1'b0, 32'h0);
        end

        // reset during WB
        instr       = mk(4'h2, 1'b0, 6'h05, 6'h04, {6'h03, 9'h000});
        instr_valid = 1'b1;
        alu_res     = 32'h55AA55AA;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("we_in_wb", 32'(we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we", 32'(we), 32'd0);
        chk("async_ready", 32'(instr_ready), 32'd1);
        chk("async_retired", 32'(retired), 32'd0);
        chk("async_wd", wd, 32'd0);
        chk("async_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_retired = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_ready", 32'(instr_ready), 32'd1);
        end
        chk("post_rst_retired", 32'(retired), 32'd0);

        // 2-bit counter wrap after 5 NOPs
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_instr(mk(4'hF, 1'b0, 6'(i + 1), 6'(i), 15'h0), $urandom, 1'b0, 32'h0);
        end
        chk("wrap_final", 32'(w_retired), 32'd1);
        chk("wide_final", 32'(retired), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
